// File: rtl/load_store_unit.sv
// Load/store unit: one memory op per transaction over a req/gnt/rvalid data port.
// Define MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of forcing alignment.
module load_store_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int FUNCT3_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [FUNCT3_LENGTH-1:0] funct3,
  input  logic [DATA_WIDTH-1:0]    ALUResult,
  input  logic [DATA_WIDTH-1:0]    store_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_err,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                   r_state;
  logic                     r_inReady;
  logic                     r_outValid;
  logic [DATA_WIDTH-1:0]    r_outData;
  logic                     r_outErr;
  logic                     r_dmemReq;
  logic                     r_dmemWe;
  logic [DATA_WIDTH-1:0]    r_dmemAddr;
  logic [DATA_WIDTH-1:0]    r_dmemWdata;
  logic [3:0]               r_dmemBe;
  logic [FUNCT3_LENGTH-1:0] r_f3;
  logic [1:0]               r_off;

  logic                  w_loadOk;
  logic                  w_storeOk;
  logic                  w_trap;
  logic                  w_illegal;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_loadData;

  assign in_ready   = r_inReady;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign out_err    = r_outErr;
  assign dmem_req   = r_dmemReq;
  assign dmem_we    = r_dmemWe;
  assign dmem_addr  = r_dmemAddr;
  assign dmem_wdata = r_dmemWdata;
  assign dmem_be    = r_dmemBe;

  // Decode the incoming op: legality, naturally aligned lane offset, lanes and enables
  always_comb begin
    w_loadOk  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_storeOk = funct3 inside {3'b000, 3'b001, 3'b010};
    w_off     = 2'b00;
    w_be      = 4'b1111;
    w_wdata   = store_data;
    w_trap    = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        w_off   = ALUResult[1:0];
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_off   = {ALUResult[1], 1'b0};
        w_be    = 4'b0011 << {ALUResult[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
`ifdef MISALIGN_TRAP_EN
        w_trap  = ALUResult[0];
`endif
      end
      default: begin
`ifdef MISALIGN_TRAP_EN
        w_trap  = |ALUResult[1:0];
`endif
      end
    endcase
    w_illegal = (mem_read & mem_write) | (mem_read & ~w_loadOk) |
                (mem_write & ~w_storeOk) | w_trap;
  end

  always_comb begin
    w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_f3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_loadData = {24'b0, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b101:  w_loadData = {16'b0, w_half};
      default: w_loadData = dmem_rdata;
    endcase
  end

  // Single-op FSM; rvalid is only honoured in WAIT or together with gnt in REQ
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_inReady   <= 1'b1;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outErr    <= 1'b0;
      r_dmemReq   <= 1'b0;
      r_dmemWe    <= 1'b0;
      r_dmemAddr  <= '0;
      r_dmemWdata <= '0;
      r_dmemBe    <= 4'b0000;
      r_f3        <= '0;
      r_off       <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && (mem_read || mem_write)) begin
            r_inReady <= 1'b0;
            r_f3      <= funct3;
            r_off     <= w_off;
            if (w_illegal) begin
              r_state    <= RESP;
              r_outValid <= 1'b1;
              r_outErr   <= 1'b1;
              r_outData  <= '0;
            end else begin
              r_state     <= REQ;
              r_dmemReq   <= 1'b1;
              r_dmemWe    <= mem_write;
              r_dmemAddr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
              r_dmemWdata <= w_wdata;
              r_dmemBe    <= w_be;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            r_dmemReq <= 1'b0;
            if (r_dmemWe) begin
              r_state    <= RESP;
              r_outValid <= 1'b1;
              r_outData  <= '0;
            end else if (dmem_rvalid) begin
              r_state    <= RESP;
              r_outValid <= 1'b1;
              r_outData  <= w_loadData;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_state    <= RESP;
            r_outValid <= 1'b1;
            r_outData  <= w_loadData;
          end
        end
        RESP: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_outErr   <= 1'b0;
            r_outData  <= '0;
            r_inReady  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle
// corner sequences, and randomized ops checked against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] store_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          gntDly;
    int          rvDly;
    int          hold;
    logic        expErr;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expBe;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[13];

  load_store_unit #(.DATA_WIDTH(32), .FUNCT3_LENGTH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .ALUResult(ALUResult), .store_data(store_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input string what,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%h want=%h", tag, what, act, exp);
    end
  endtask

  // Reference model: works in terms of access size in bytes and byte arithmetic
  function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] rdata, input int gd, input int rv,
                                 input int hold);
    vec_t   v;
    int     size;
    int     lo;
    int     off;
    logic   legal;
    logic   mis;
    longint val;
    v = '{rd, wr, f3, addr, sd, rdata, gd, rv, hold, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
    size = 1 << f3[1:0];
    if (rd && wr)  legal = 1'b0;
    else if (rd)   legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else           legal = (f3 == 0 || f3 == 1 || f3 == 2);
    lo  = int'(addr % 4);
    mis = (size <= 4) && ((lo % size) != 0);
`ifdef MISALIGN_TRAP_EN
    v.expErr = !legal || mis;
`else
    v.expErr = !legal;
`endif
    if (!v.expErr) begin
      off        = lo - (lo % size);
      v.expAddr  = addr - 32'(lo);
      v.expBe    = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++)
        v.expWdata = v.expWdata | (((sd >> (8 * (i % size))) & 32'hFF) << (8 * i));
      if (rd) begin
        val = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
          val = val - (longint'(1) << (8 * size));
        v.expData = val[31:0];
      end
    end
    return v;
  endfunction

  // Drive one op end to end, playing the memory side with the vector's delays
  task automatic applyStimulus(input vec_t v, input string tag);
    checkOutput(tag, "inReadyIdle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    ALUResult = v.addr; store_data = v.sd; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'($urandom); ALUResult = $urandom; store_data = $urandom;
    checkOutput(tag, "inReadyBusy", 32'(in_ready), 32'd0);
    if (v.expErr) begin
      checkOutput(tag, "noReq", 32'(dmem_req), 32'd0);
    end else begin
      for (int c = 0; c <= v.gntDly; c++) begin
        checkOutput(tag, "req", 32'(dmem_req), 32'd1);
        checkOutput(tag, "addr", dmem_addr, v.expAddr);
        checkOutput(tag, "we", 32'(dmem_we), 32'(v.wr));
        checkOutput(tag, "be", 32'(dmem_be), 32'(v.expBe));
        if (v.wr) checkOutput(tag, "wdata", dmem_wdata, v.expWdata);
        checkOutput(tag, "inReadyReq", 32'(in_ready), 32'd0);
        checkOutput(tag, "noValidReq", 32'(out_valid), 32'd0);
        if (c == v.gntDly) begin
          dmem_gnt = 1'b1;
          if (v.rd && v.rvDly == 0) begin
            dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
          end
        end else begin
          dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        end
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
      if (v.rd && v.rvDly > 0) begin
        for (int c = 1; c < v.rvDly; c++) begin
          checkOutput(tag, "waitNoReq", 32'(dmem_req), 32'd0);
          checkOutput(tag, "waitNoValid", 32'(out_valid), 32'd0);
          @(negedge clk);
        end
        checkOutput(tag, "waitNoReq", 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      end
    end
    for (int h = 0; h <= v.hold; h++) begin
      checkOutput(tag, "outValid", 32'(out_valid), 32'd1);
      checkOutput(tag, "outData", out_data, v.expErr ? 32'h0 : v.expData);
      checkOutput(tag, "outErr", 32'(out_err), 32'(v.expErr));
      checkOutput(tag, "inReadyResp", 32'(in_ready), 32'd0);
      if (h == v.hold) out_ready = 1'b1;
      dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(negedge clk);
      dmem_rvalid = 1'b0;
    end
    out_ready = 1'b0;
    checkOutput(tag, "doneValid", 32'(out_valid), 32'd0);
    checkOutput(tag, "doneReady", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t rv;
    logic rd, wr;
    logic [2:0] f3;
    int kind;

    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
    ALUResult = 32'h0; store_data = 32'h0; out_ready = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset", "inReady", 32'(in_ready), 32'd1);
    checkOutput("reset", "outValid", 32'(out_valid), 32'd0);
    checkOutput("reset", "outData", out_data, 32'h0);
    checkOutput("reset", "outErr", 32'(out_err), 32'd0);
    checkOutput("reset", "req", 32'(dmem_req), 32'd0);
    checkOutput("reset", "we", 32'(dmem_we), 32'd0);
    checkOutput("reset", "addr", dmem_addr, 32'h0);
    checkOutput("reset", "wdata", dmem_wdata, 32'h0);
    checkOutput("reset", "be", 32'(dmem_be), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // rd wr f3 addr sd rdata gntDly rvDly hold | err addr wdata be data
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0,
                 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 3, 0,
                 1'b0, 32'h0000_2000, 32'h0, 4'b0100, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 3, 0,
                 1'b0, 32'h0000_2000, 32'h0, 4'b0100, 32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 1, 0,
                 1'b0, 32'h0000_2000, 32'h0, 4'b1100, 32'hFFFF_8001};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 4, 1, 0,
                 1'b0, 32'h0000_2000, 32'h0, 4'b1111, 32'hDEAD_BEEF};
`ifdef MISALIGN_TRAP_EN
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h1122_3344, 0, 0, 0,
                 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0};
`else
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h1122_3344, 0, 0, 0,
                 1'b0, 32'h0000_3000, 32'h0, 4'b1111, 32'h1122_3344};
`endif
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_4006, 32'h1234_ABCD, 32'h0, 1, 0, 5,
                 1'b0, 32'h0000_4004, 32'hABCD_ABCD, 4'b1100, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'b011, 32'h0000_5000, 32'h0, 32'h0, 0, 0, 1,
                 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b100, 32'h0000_5000, 32'h0, 32'h0, 0, 0, 0,
                 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 0, 0, 0,
                 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b101, 32'h0000_5000, 32'h0, 32'h0000_F00F, 2, 2, 0,
                 1'b0, 32'h0000_5000, 32'h0, 4'b0011, 32'h0000_F00F};
    vecs[11] = '{1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'hCAFE_F00D, 32'h0, 0, 0, 0,
                 1'b0, 32'h0000_6004, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_7001, 32'h0, 32'h0000_7F00, 0, 0, 2,
                 1'b0, 32'h0000_7000, 32'h0, 4'b0010, 32'h0000_007F};

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset while a request is outstanding, then a late response must be dropped
    in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_0100;
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0;
    checkOutput("rstReq", "reqBefore", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstReq", "reqFirstEdge", 32'(dmem_req), 32'd0);
    checkOutput("rstReq", "readyFirstEdge", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("rstReq", "noValid", 32'(out_valid), 32'd0);
      checkOutput("rstReq", "ready", 32'(in_ready), 32'd1);
      checkOutput("rstReq", "noReq", 32'(dmem_req), 32'd0);
      @(negedge clk);
    end

    // An in_valid carrying neither read nor write is not accepted
    in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; ALUResult = 32'h0000_0200;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("noOp", "ready", 32'(in_ready), 32'd1);
    checkOutput("noOp", "noReq", 32'(dmem_req), 32'd0);
    checkOutput("noOp", "noValid", 32'(out_valid), 32'd0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rd = (kind <= 5);
      wr = (kind == 0) || (kind >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd && !wr) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      rv = model(rd, wr, f3, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      applyStimulus(rv, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
